// File: rtl/riscv_multicycle_control.sv
// Multi-cycle control FSM for the 64-bit load/store/ALU/branch datapath.
// Optional performance counters are enabled by defining CONTROL_PERF_CNT_EN.
module riscv_multicycle_control #(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        selectedFlag,
    output logic [63:0] immediate,
    output logic [4:0]  readRegister1,
    output logic [4:0]  readRegister2,
    output logic [4:0]  writeRegister,
    output logic [2:0]  funct3,
    output logic        writeEnable_DataMemory,
    output logic        writeEnable_Registers,
    output logic        muxSelect_SumVsReadData,
    output logic        muxSelect_ImmVsDataout2,
    output logic        SumOrSub,
    output logic [63:0] pc,
    output logic        busy,
    output logic        illegal
`ifdef CONTROL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {
        CLS_LD, CLS_SD, CLS_ADDI, CLS_RTYPE, CLS_BRANCH, CLS_ILLEGAL
    } opClass_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] ir;
    logic [63:0] pcNext;
    opClass_t    irClass;
    opClass_t    capClass;
    logic        capture;
    logic        retire;

    function automatic opClass_t classify(input logic [31:0] w);
        opClass_t c;
        c = CLS_ILLEGAL;
        case (w[6:0])
            7'b0000011: if (w[14:12] == 3'b011) c = CLS_LD;
            7'b0100011: if (w[14:12] == 3'b011) c = CLS_SD;
            7'b0010011: if (w[14:12] == 3'b000) c = CLS_ADDI;
            7'b0110011:
                if (w[14:12] == 3'b000 &&
                    (w[31:25] == 7'b0000000 || w[31:25] == 7'b0100000))
                    c = CLS_RTYPE;
            7'b1100011:
                if (w[14:12] != 3'b010 && w[14:12] != 3'b011) c = CLS_BRANCH;
            default: c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [63:0] decodeImm(input logic [31:0] w, input opClass_t c);
        logic [63:0] v;
        v = '0;
        case (c)
            CLS_LD, CLS_ADDI: v = {{52{w[31]}}, w[31:20]};
            CLS_SD:           v = {{52{w[31]}}, w[31:25], w[11:7]};
            CLS_BRANCH:       v = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default:          v = '0;
        endcase
        return v;
    endfunction

    assign irClass  = classify(ir);
    assign capClass = classify(instruction);
    assign capture  = (state == FETCH) && instr_valid;

    assign instr_ready   = (state == FETCH);
    assign busy          = (state != FETCH);
    assign readRegister1 = ir[19:15];
    assign readRegister2 = ir[24:20];
    assign writeRegister = ir[11:7];
    assign funct3        = ir[14:12];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= PC_RESET;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        case (state)
            FETCH: if (instr_valid) stateNext = DECODE;
            DECODE: begin
                if (irClass == CLS_ILLEGAL) begin
                    stateNext = FETCH;
                    pcNext    = pc + PC_STEP;
                end else begin
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                case (irClass)
                    CLS_BRANCH: begin
                        stateNext = FETCH;
                        pcNext    = pc + (selectedFlag ? immediate : PC_STEP);
                    end
                    CLS_LD, CLS_SD: stateNext = MEM;
                    default:        stateNext = WB;
                endcase
            end
            MEM: begin
                if (irClass == CLS_SD) begin
                    stateNext = FETCH;
                    pcNext    = pc + PC_STEP;
                end else begin
                    stateNext = WB;
                end
            end
            WB: begin
                stateNext = FETCH;
                pcNext    = pc + PC_STEP;
            end
            default: stateNext = FETCH;
        endcase
    end

    assign retire = (state != FETCH) && (stateNext == FETCH) && (irClass != CLS_ILLEGAL);

    // Decoded fields are taken from the incoming word on the capture edge so
    // they are already valid during DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir                      <= '0;
            immediate               <= '0;
            muxSelect_ImmVsDataout2 <= 1'b0;
            muxSelect_SumVsReadData <= 1'b0;
            SumOrSub                <= 1'b0;
            illegal                 <= 1'b0;
        end else begin
            illegal <= capture && (capClass == CLS_ILLEGAL);
            if (capture) begin
                ir                      <= instruction;
                immediate               <= decodeImm(instruction, capClass);
                muxSelect_ImmVsDataout2 <= (capClass == CLS_LD) || (capClass == CLS_SD) ||
                                           (capClass == CLS_ADDI);
                muxSelect_SumVsReadData <= (capClass != CLS_LD);
                SumOrSub                <= (capClass == CLS_BRANCH) ||
                                           ((capClass == CLS_RTYPE) && instruction[30]);
            end
        end
    end

    // Strobes are loaded from the next state so they are high exactly in MEM/WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeEnable_DataMemory <= 1'b0;
            writeEnable_Registers  <= 1'b0;
        end else begin
            writeEnable_DataMemory <= (stateNext == MEM) && (irClass == CLS_SD);
            writeEnable_Registers  <= (stateNext == WB) && (ir[11:7] != 5'd0);
        end
    end

`ifdef CONTROL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (retire) instret_count <= instret_count + 32'd1;
        end
    end
`else
    logic unusedRetire;
    assign unusedRetire = retire;
`endif

endmodule

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
- Multi-cycle control FSM that sequences the 64-bit load/store/ALU/branch datapath.
- Accepts one 32-bit RV64 instruction per handshake and decodes register addresses, immediate and funct3.
- Drives the datapath write enables and mux/adder selects.
- Maintains the PC, using the datapath's selectedFlag to resolve branches.

Parameters:
- PC_RESET, 64'h0, PC value loaded on reset.
- PC_STEP, 4, increment for sequential and not-taken instructions.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  instruction word presented by the fetch source.
- instr_valid  in  1  instruction is valid.
- instr_ready  out  1  controller can accept an instruction (FETCH state only).
- selectedFlag  in  1  branch condition from the datapath flag mux.
- immediate  out  64  sign-extended immediate (I/S/B format per opcode).
- readRegister1  out  5  rs1 = IR[19:15].
- readRegister2  out  5  rs2 = IR[24:20].
- writeRegister  out  5  rd = IR[11:7].
- funct3  out  3  IR[14:12].
- writeEnable_DataMemory  out  1  memory store strobe.
- writeEnable_Registers  out  1  register-file write strobe.
- muxSelect_SumVsReadData  out  1  1 = adder sum to register file; 0 = memory read data.
- muxSelect_ImmVsDataout2  out  1  1 = immediate to adder B; 0 = dataOut2.
- SumOrSub  out  1  1 = subtract.
- pc  out  64  current instruction address.
- busy  out  1  high in every state except FETCH.
- illegal  out  1  one-cycle pulse on an unsupported encoding.

Behaviour:
- Reset (asynchronous): state = FETCH; pc = PC_RESET; IR = 0; all strobes, busy and illegal = 0. Reset mid-instruction aborts it with no write.
- FETCH: instr_ready = 1. On instr_valid, capture IR and go to DECODE. Otherwise hold.
- DECODE: select the immediate format by opcode.
  - 0000011 (LD, funct3 011): I-type.
  - 0100011 (SD, funct3 011): S-type.
  - 0010011 (ADDI, funct3 000): I-type.
  - 0110011 (ADD/SUB, funct3 000, funct7 0000000/0100000): no immediate.
  - 1100011 (branch, funct3 000/001/100/101/110/111): B-type.
  - Anything else: pulse illegal, pc += PC_STEP, go to FETCH.
- Decoded fields (immediate, register addresses, funct3, mux selects, SumOrSub) are registered from IR. They are stable from DECODE until the next capture.
  - muxSelect_ImmVsDataout2 = 1 for LD, SD and ADDI; 0 for R-type and branch.
  - SumOrSub = 1 for SUB and branch; 0 otherwise.
- EXEC: one cycle for adder settle.
  - Branch: at end of EXEC, pc += immediate if selectedFlag = 1, else pc += PC_STEP; then FETCH.
  - LD and SD: go to MEM.
  - R-type and ADDI: go to WB.
- MEM:
  - SD: writeEnable_DataMemory = 1 for exactly this cycle; pc += PC_STEP; go to FETCH.
  - LD: no strobe; go to WB.
- WB: muxSelect_SumVsReadData = 0 for LD, 1 otherwise. writeEnable_Registers = 1 for exactly one cycle; pc += PC_STEP; go to FETCH.
- rd = x0: writeEnable_Registers stays 0, but the WB state is still traversed.
- Latencies from the capture edge to the next instr_ready:
  - Branch: 3 cycles.
  - ADD/SUB/ADDI: 4 cycles.
  - SD: 4 cycles.
  - LD: 5 cycles.
  - Illegal: 2 cycles.
- pc arithmetic is 64-bit modulo. Wrap from 64'hFFFF_FFFF_FFFF_FFFC + 4 gives 0 with no flag.
- Strobes are Moore outputs, registered so they are glitch-free. Never more than one strobe is high in any cycle.
- instr_valid is ignored outside FETCH; instruction may change freely while busy.

Optional Feature:
- Macro CONTROL_PERF_CNT_EN.
- When defined, add output ports cycle_count[31:0] and instret_count[31:0]:
  - cycle_count increments every cycle after reset.
  - instret_count increments on each return to FETCH from a legal instruction.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with PC_RESET = 64'h100 -> pc = 64'h100, instr_ready = 1, all strobes 0; assert reset in mid-LD -> no writeEnable_Registers pulse, state back to FETCH.
- ADDI x5,x2,-8 (32'hFF810293) -> immediate = 64'hFFFF_FFFF_FFFF_FFF8, muxSelect_ImmVsDataout2 = 1, one writeEnable_Registers pulse with writeRegister = 5 four cycles after capture, pc += 4.
- SD x1,16(x2) then LD x3,16(x2) -> SD gives a single writeEnable_DataMemory pulse in MEM; LD gives a WB write with muxSelect_SumVsReadData = 0, 5-cycle latency.
- BEQ imm = +32 with selectedFlag = 1 -> pc += 32, SumOrSub = 1; repeat with selectedFlag = 0 -> pc += 4; 3-cycle latency; no strobes.
- Opcode 7'b1111111 -> one illegal pulse, pc += 4, no strobes; ADD with rd = x0 -> no register write.
- instr_valid held low for 10 cycles -> controller stays in FETCH with instr_ready = 1, pc unchanged; with CONTROL_PERF_CNT_EN, cycle_count advances while instret_count holds.
